multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequential successor to the single-cycle combinational control decode of the MIPS datapath.
- Drives a shared-memory, multicycle datapath (PC, IR, A/B, ALUOut, MDR registers) through a Moore FSM.
- Adds a memory ready handshake with a timeout counter, optional ADDI/BNE support, and an illegal-opcode trap to a parametrised vector.
- Sits between the instruction register opcode field and the datapath mux/enable inputs.

Parameters:
- ENABLE_ADDI, 1, decode opcode 0x08 (addi); when 0, 0x08 traps as illegal.
- ENABLE_BNE, 1, decode opcode 0x05 (bne); when 0, 0x05 traps as illegal.
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready; 0 disables the timeout.
- TIMER_W, 5, width of the wait counter; must be ≥ $clog2(MEM_TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- instrn_opcode  input  6  IR[31:26]
- zero_out  input  1  ALU zero flag
- mem_ready  input  1  memory completed the access this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  write strobe, valid with mem_req
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_en  output  1  load IR from memory read data
- pc_write_en  output  1  load PC
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = trap vector
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = A register
- alu_src_b  output  2  ALU B input: 00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- reg_write_en  output  1  register file write
- reg_dst  output  1  write address: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- instr_retired  output  1  one-cycle pulse when an instruction completes
- trap  output  1  one-cycle pulse on illegal opcode or memory timeout
- trap_cause  output  1  0 = illegal opcode, 1 = timeout; held until the next trap

Behaviour:
- Clocking and reset
  - Single clock, clk.
  - Reset is synchronous and active-high on rst; it is checked before any transition and forces state to IDLE, wait counter to 0, and trap_cause to 0.
  - Reset mid-access drops mem_req on the next cycle; no retire or trap pulse is issued.
- Outputs
  - Moore: decoded only from the state register, except the mem_ready/zero_out qualified enables listed below.
  - Every output not listed for a state is 0.
  - In IDLE all outputs are 0. IDLE always moves to FETCH on the next cycle.
- States, 4-bit encoding:
  - FETCH: mem_req=1, iord=0, alu_src_b=01, alu_op=00, pc_src=00.
    - ir_write_en = pc_write_en = mem_ready.
    - On mem_ready go to DECODE; otherwise stay.
  - DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0x00 → EXEC_R
    - 0x23 or 0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x05 → BRANCH if ENABLE_BNE
    - 0x02 → JUMP
    - 0x08 → EXEC_I if ENABLE_ADDI
    - anything else → TRAP, trap_cause=0
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_READ for 0x23, MEM_WRITE for 0x2B.
  - MEM_READ: mem_req=1, iord=1. On mem_ready go to MEM_WB.
  - MEM_WB: reg_write_en=1, reg_dst=0, mem_to_reg=1, instr_retired=1. Then FETCH.
  - MEM_WRITE: mem_req=1, mem_we=1, iord=1. On mem_ready: instr_retired=1, go to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
  - R_WB: reg_write_en=1, reg_dst=1, mem_to_reg=0, instr_retired=1. Then FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Then I_WB.
  - I_WB: reg_write_en=1, reg_dst=0, mem_to_reg=0, instr_retired=1. Then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, instr_retired=1. Then FETCH.
    - pc_write_en = zero_out for 0x04, !zero_out for 0x05.
  - JUMP: pc_write_en=1, pc_src=10, instr_retired=1. Then FETCH.
  - TRAP: pc_write_en=1, pc_src=11, trap=1, instr_retired=0. Then FETCH.
- Wait counter (applies in FETCH, MEM_READ, MEM_WRITE)
  - Cleared on entry to any of these states; increments each cycle mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0, the next state is TRAP with trap_cause=1.
  - mem_ready in the same cycle as that limit wins: the access completes normally.
- Latencies with zero-wait memory:
  - R-type, ADDI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne, j: 3 cycles
  - trap: 3 cycles
- mem_ready outside a memory state is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 0x00, OP_J 0x02, OP_BEQ 0x04, OP_BNE 0x05, OP_ADDI 0x08, OP_LW 0x23, OP_SW 0x2B
  - ALU-op, pc_src, and alu_src_b encodings
  - the state enum typedef
- One sub-module, mem_wait_timer, implements the wait counter and timeout compare.

Test Plan:
- Reset then R-type (opcode 0x00), mem_ready always 1:
  - 4 cycles after FETCH entry, R_WB shows reg_write_en=1, reg_dst=1, with one instr_retired pulse.
- lw (0x23) with mem_ready delayed 3 cycles in FETCH and 2 in MEM_READ:
  - mem_req held high throughout each wait; ir_write_en high only in the mem_ready cycle.
  - MEM_WB has mem_to_reg=1; 10 cycles total.
- beq (0x04) with zero_out=1 then zero_out=0:
  - pc_write_en=1, pc_src=01 in the first case; pc_write_en=0 in the second.
  - Repeat with bne (0x05): results inverted.
- Opcode 0x3F, and separately 0x08 with ENABLE_ADDI=0:
  - TRAP reached: trap=1, trap_cause=0, pc_src=11, pc_write_en=1, no instr_retired.
- MEM_TIMEOUT=4, mem_ready held 0 during sw:
  - TRAP entered after 4 MEM_WRITE cycles with trap_cause=1.
  - Repeat with mem_ready=1 on cycle 4: normal retire, no trap.
- rst asserted in MEM_READ:
  - Next cycle state is IDLE with all outputs 0, then FETCH one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg: opcodes, datapath mux encodings and control FSM states     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control_if: control unit <-> datapath/memory signal group |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface multicycle_control_if;

  logic [5:0] instrn_opcode;
  logic       zero_out;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write_en;
  logic       pc_write_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write_en;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_retired;
  logic       trap;
  logic       trap_cause;

  modport master (
    input  instrn_opcode, zero_out, mem_ready,
    output mem_req, mem_we, iord, ir_write_en, pc_write_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write_en, reg_dst,
           mem_to_reg, instr_retired, trap, trap_cause
  );

  modport slave (
    output instrn_opcode, zero_out, mem_ready,
    input  mem_req, mem_we, iord, ir_write_en, pc_write_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write_en, reg_dst,
           mem_to_reg, instr_retired, trap, trap_cause
  );

endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wait_timer: counts unanswered memory cycles, flags the timeout   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMER_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [TIMER_W-1:0] r_count;

  // Every exit from a memory state is via ready or expiry, so clearing on
  // those also gives a clean count on entry to the next memory state.
  always_ff @(posedge clk) begin
    if (rst || !active || ready || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  if (MEM_TIMEOUT > 0) begin : g_timeout
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT - 1);
    assign expired = active && !ready && (r_count == LIMIT);
  end else begin : g_no_timeout
    assign expired = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control: Moore control FSM for the multicycle MIPS path   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multicycle_control
  import mips_pkg::*;
#(
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_BNE  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMER_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_t r_state;
  state_t w_next;
  logic   r_trap_cause;
  logic   w_in_mem;
  logic   w_expired;

  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                    (r_state == S_MEM_WRITE);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMER_W     (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (w_in_mem),
    .ready   (bus.mem_ready),
    .expired (w_expired)
  );

  // Expiry is only possible in a memory state, so it alone tells the two
  // trap causes apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trap_cause <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) begin
        r_trap_cause <= w_expired;
      end
    end
  end

  assign bus.trap_cause = r_trap_cause;

  always_comb begin
    w_next            = r_state;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write_en   = 1'b0;
    bus.pc_write_en   = 1'b0;
    bus.pc_src        = PC_ALU;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALU_ADD;
    bus.reg_write_en  = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.instr_retired = 1'b0;
    bus.trap          = 1'b0;

    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.mem_req     = 1'b1;
        bus.alu_src_b   = SRCB_FOUR;
        bus.ir_write_en = bus.mem_ready;
        bus.pc_write_en = bus.mem_ready;
        if (bus.mem_ready)   w_next = S_DECODE;
        else if (w_expired)  w_next = S_TRAP;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        w_next        = S_TRAP;
        case (bus.instrn_opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_BNE:       if (ENABLE_BNE != 0) w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      if (ENABLE_ADDI != 0) w_next = S_EXEC_I;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next = (bus.instrn_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready)  w_next = S_MEM_WB;
        else if (w_expired) w_next = S_TRAP;
      end
      S_MEM_WB: begin
        bus.reg_write_en  = 1'b1;
        bus.mem_to_reg    = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_req       = 1'b1;
        bus.mem_we        = 1'b1;
        bus.iord          = 1'b1;
        bus.instr_retired = bus.mem_ready;
        if (bus.mem_ready)  w_next = S_FETCH;
        else if (w_expired) w_next = S_TRAP;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        w_next        = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write_en  = 1'b1;
        bus.reg_dst       = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next        = S_I_WB;
      end
      S_I_WB: begin
        bus.reg_write_en  = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_src        = PC_ALUOUT;
        bus.instr_retired = 1'b1;
        bus.pc_write_en   = (bus.instrn_opcode == OP_BNE) ? !bus.zero_out : bus.zero_out;
        w_next            = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write_en   = 1'b1;
        bus.pc_src        = PC_JUMP;
        bus.instr_retired = 1'b1;
        w_next            = S_FETCH;
      end
      S_TRAP: begin
        bus.pc_write_en = 1'b1;
        bus.pc_src      = PC_TRAP;
        bus.trap        = 1'b1;
        w_next          = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_control: vector table, corner sequences, random mix    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if if0();
  multicycle_control_if if1();

  multicycle_control #(.ENABLE_ADDI(1), .ENABLE_BNE(1), .MEM_TIMEOUT(16), .TIMER_W(5))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  multicycle_control #(.ENABLE_ADDI(0), .ENABLE_BNE(0), .MEM_TIMEOUT(4), .TIMER_W(3))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write_en;
    logic       pc_write_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_retired;
    logic       trap;
    logic       trap_cause;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    bit         rdy;
    bit         z;
    outs_t      exp;
  } step_t;

  typedef struct {
    int         d;
    logic [5:0] op;
    bit         z;
    int         wf;
    int         wm;
    int         cycles;
  } vec_t;

  typedef enum int {P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWB, P_MWRITE,
                    P_EXR, P_RWB, P_EXI, P_IWB, P_BR, P_J, P_TRAP} ph_t;

  outs_t got0, got1;
  assign got0 = {if0.mem_req, if0.mem_we, if0.iord, if0.ir_write_en, if0.pc_write_en,
                 if0.pc_src, if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.reg_write_en,
                 if0.reg_dst, if0.mem_to_reg, if0.instr_retired, if0.trap, if0.trap_cause};
  assign got1 = {if1.mem_req, if1.mem_we, if1.iord, if1.ir_write_en, if1.pc_write_en,
                 if1.pc_src, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.reg_write_en,
                 if1.reg_dst, if1.mem_to_reg, if1.instr_retired, if1.trap, if1.trap_cause};

  int    checks = 0;
  int    failures = 0;
  step_t plan[$];
  bit    m_cause;
  vec_t  vecs[17];
  logic [5:0] ops[8];

  function automatic bit rbit();
    return ($urandom & 1) != 0;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Expected control word for one cycle of an instruction phase.
  function automatic outs_t phase_out(ph_t p, bit rdy, bit z, logic [5:0] op, bit cause);
    outs_t o;
    o = '0;
    o.trap_cause = cause;
    case (p)
      P_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write_en = rdy; o.pc_write_en = rdy; end
      P_DECODE: o.alu_src_b = 2'b11;
      P_MADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MREAD:  begin o.mem_req = 1; o.iord = 1; end
      P_MWB:    begin o.reg_write_en = 1; o.mem_to_reg = 1; o.instr_retired = 1; end
      P_MWRITE: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.instr_retired = rdy; end
      P_EXR:    begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      P_RWB:    begin o.reg_write_en = 1; o.reg_dst = 1; o.instr_retired = 1; end
      P_EXI:    begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_IWB:    begin o.reg_write_en = 1; o.instr_retired = 1; end
      P_BR:     begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.instr_retired = 1;
                      o.pc_write_en = (op == 6'h05) ? !z : z; end
      P_J:      begin o.pc_write_en = 1; o.pc_src = 2'b10; o.instr_retired = 1; end
      P_TRAP:   begin o.pc_write_en = 1; o.pc_src = 2'b11; o.trap = 1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input ph_t p, input bit rdy, input bit z, input logic [5:0] op);
    step_t s;
    s.op = op; s.rdy = rdy; s.z = z;
    s.exp = phase_out(p, rdy, z, op, m_cause);
    plan.push_back(s);
  endtask

  // A memory phase waits w cycles, unless the timeout T cuts it short.
  task automatic mem_phase(input ph_t p, input int w, input int T, input logic [5:0] op,
                           output bit to);
    int n;
    to = (T > 0) && (w >= T);
    n  = to ? T : w;
    for (int i = 0; i < n; i++) push(p, 1'b0, rbit(), op);
    if (to) begin
      m_cause = 1'b1;
      push(P_TRAP, rbit(), rbit(), op);
    end else begin
      push(p, 1'b1, rbit(), op);
    end
  endtask

  task automatic trap_illegal(input logic [5:0] op);
    m_cause = 1'b0;
    push(P_TRAP, rbit(), rbit(), op);
  endtask

  task automatic plan_instr(input int d, input logic [5:0] op, input bit z,
                            input int wf, input int wm);
    int T;
    bit en;
    bit to;
    T  = (d == 0) ? 16 : 4;
    en = (d == 0);
    mem_phase(P_FETCH, wf, T, op, to);
    if (to) return;
    push(P_DECODE, rbit(), rbit(), op);
    case (op)
      6'h00: begin push(P_EXR, rbit(), rbit(), op); push(P_RWB, rbit(), rbit(), op); end
      6'h23: begin
        push(P_MADDR, rbit(), rbit(), op);
        mem_phase(P_MREAD, wm, T, op, to);
        if (!to) push(P_MWB, rbit(), rbit(), op);
      end
      6'h2B: begin push(P_MADDR, rbit(), rbit(), op); mem_phase(P_MWRITE, wm, T, op, to); end
      6'h04: push(P_BR, rbit(), z, op);
      6'h05: if (en) push(P_BR, rbit(), z, op); else trap_illegal(op);
      6'h02: push(P_J, rbit(), rbit(), op);
      6'h08: if (en) begin push(P_EXI, rbit(), rbit(), op); push(P_IWB, rbit(), rbit(), op); end
             else trap_illegal(op);
      default: trap_illegal(op);
    endcase
  endtask

  task automatic drive(input int d, input step_t s);
    if (d == 0) begin
      if0.instrn_opcode = s.op; if0.zero_out = s.z; if0.mem_ready = s.rdy;
    end else begin
      if1.instrn_opcode = s.op; if1.zero_out = s.z; if1.mem_ready = s.rdy;
    end
  endtask

  task automatic run_plan(input int d, input string name, input int max_steps, output int lat);
    int n;
    outs_t g;
    n = plan.size();
    if (max_steps < n) n = max_steps;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(d, plan[i]);
      @(negedge clk);
      g = (d == 0) ? got0 : got1;
      check($sformatf("%s_c%0d", name, i), g, plan[i].exp);
      if (lat < 0 && (g.instr_retired || g.trap)) lat = i + 1;
    end
    plan.delete();
  endtask

  task automatic drive_idle();
    if0.instrn_opcode = '0; if0.zero_out = 1'b0; if0.mem_ready = 1'b0;
    if1.instrn_opcode = '0; if1.zero_out = 1'b0; if1.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dut0", got0, '0);
    check("reset_dut1", got1, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_dut0", got0, '0);
    check("idle_dut1", got1, '0);
    m_cause = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{0, 6'h00, 1'b0, 0, 0, 4};
    vecs[1]  = '{0, 6'h23, 1'b0, 3, 2, 10};
    vecs[2]  = '{0, 6'h2B, 1'b0, 0, 0, 4};
    vecs[3]  = '{0, 6'h04, 1'b1, 0, 0, 3};
    vecs[4]  = '{0, 6'h04, 1'b0, 0, 0, 3};
    vecs[5]  = '{0, 6'h05, 1'b1, 0, 0, 3};
    vecs[6]  = '{0, 6'h05, 1'b0, 0, 0, 3};
    vecs[7]  = '{0, 6'h02, 1'b0, 0, 0, 3};
    vecs[8]  = '{0, 6'h08, 1'b0, 0, 0, 4};
    vecs[9]  = '{0, 6'h3F, 1'b0, 0, 0, 3};
    vecs[10] = '{0, 6'h23, 1'b0, 0, 0, 5};
    vecs[11] = '{1, 6'h08, 1'b0, 0, 0, 3};
    vecs[12] = '{1, 6'h05, 1'b0, 0, 0, 3};
    vecs[13] = '{1, 6'h2B, 1'b0, 0, 4, 8};
    vecs[14] = '{1, 6'h2B, 1'b0, 0, 3, 7};
    vecs[15] = '{1, 6'h23, 1'b0, 4, 0, 5};
    vecs[16] = '{1, 6'h00, 1'b0, 0, 0, 4};
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F};

    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int i = 0; i < 17; i++) begin
        if (vecs[i].d == d) begin
          plan_instr(d, vecs[i].op, vecs[i].z, vecs[i].wf, vecs[i].wm);
          run_plan(d, $sformatf("vec%0d", i), 1000, lat);
          check_int($sformatf("vec%0d_latency", i), lat, vecs[i].cycles);
        end
      end
      for (int k = 0; k < 40; k++) begin
        int T, idx, wf, wm;
        logic [5:0] op;
        T   = (d == 0) ? 16 : 4;
        idx = $urandom_range(0, 8);
        op  = (idx == 8) ? 6'($urandom) : ops[idx];
        wf  = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
        wm  = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
        plan_instr(d, op, rbit(), wf, wm);
        run_plan(d, $sformatf("rnd%0d_%0d", d, k), 1000, lat);
      end
      if (d == 0) begin
        // Reset lands while a load is still waiting on memory.
        plan_instr(0, 6'h23, 1'b0, 0, 3);
        run_plan(0, "rst_pre", 4, lat);
        @(posedge clk); #1;
        rst = 1'b1;
        if0.mem_ready = 1'b0;
        @(negedge clk);
        check("rst_in_read", got0, phase_out(P_MREAD, 1'b0, 1'b0, 6'h23, m_cause));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle", got0, '0);
        m_cause = 1'b0;
        plan_instr(0, 6'h00, 1'b0, 0, 0);
        run_plan(0, "rst_post", 1000, lat);
        check_int("rst_post_latency", lat, 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
